// File: rtl/decimator_pkg.sv
// Shared types for the decimator: gate-window tracking states.
package decimator_pkg;

  typedef enum logic [2:0] {
    S_SETTLE0,   // synchronizer still holding its reset value
    S_SETTLE1,
    S_WAIT_LOW,  // gate must be seen low before a window may open
    S_CLOSED,
    S_OPEN
  } win_state_t;

endpackage

// File: rtl/decimator_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/decimator.sv
// Gated sample-strobe decimator: emits one o_sample pulse every N active
// cycles inside an acquisition gate window while IAGC is enabled and acquiring.
module decimator
  import decimator_pkg::*;
#(
  parameter int unsigned DECIMATOR_SIZE = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [3:0]                i_iagc_status,
  input  logic                      i_gate,
  input  logic [DECIMATOR_SIZE-1:0] i_decimator,
  output logic                      o_sample
);

  localparam int unsigned ENABLE  = 0;
  localparam int unsigned ACQUIRE = 1;

  logic                      gate_s;
  logic                      opening;
  logic                      window;
  logic                      active;
  logic [DECIMATOR_SIZE-1:0] n_q;
  logic [DECIMATOR_SIZE-1:0] n_eff;
  logic [DECIMATOR_SIZE-1:0] cnt;
  logic [DECIMATOR_SIZE-1:0] cnt_next;
  logic                      sample_next;
  logic                      unused_status;
  win_state_t                state;
  win_state_t                state_next;

  assign unused_status = ^i_iagc_status[3:2];

  sync_2ff u_sync (
    .clk (i_clock),
    .rst (i_reset),
    .d   (i_gate),
    .q   (gate_s)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= S_SETTLE0;
    else         state <= state_next;
  end

  // The settle states keep the synchronizer's post-reset 0->1 ramp from
  // looking like a gate rise; a window needs a genuine low-then-high gate.
  always_comb begin
    state_next = state;
    opening    = 1'b0;
    case (state)
      S_SETTLE0:  state_next = S_SETTLE1;
      S_SETTLE1:  state_next = S_WAIT_LOW;
      S_WAIT_LOW: if (!gate_s) state_next = S_CLOSED;
      S_CLOSED: begin
        if (gate_s) begin
          state_next = S_OPEN;
          opening    = 1'b1;
        end
      end
      S_OPEN:     if (!gate_s) state_next = S_CLOSED;
      default:    state_next = S_SETTLE0;
    endcase
  end

  // The opening cycle already counts, using the factor being latched.
  assign window = opening || ((state == S_OPEN) && gate_s);
  assign active = i_iagc_status[ENABLE] && i_iagc_status[ACQUIRE] && window;
  assign n_eff  = opening ? i_decimator : n_q;

  always_comb begin
    cnt_next    = '0;
    sample_next = 1'b0;
    if (active && (n_eff != '0)) begin
      if (cnt == n_eff - 1'b1) begin
        sample_next = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      n_q      <= '0;
      cnt      <= '0;
      o_sample <= 1'b0;
    end else begin
      if (opening) n_q <= i_decimator;
      cnt      <= cnt_next;
      o_sample <= sample_next;
    end
  end

endmodule

// File: tb/tb_decimator.sv
// Scoreboard bench for decimator: per-cycle expected strobe values are queued
// as stimulus is driven and compared on the falling edge after each clock.
module tb_decimator;

  localparam int unsigned W = 4;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic [3:0]   i_iagc_status;
  logic         i_gate;
  logic [W-1:0] i_decimator;
  logic         o_sample;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic        exp_q[$];

  always #5 i_clock = ~i_clock;

  decimator #(.DECIMATOR_SIZE(W)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_iagc_status (i_iagc_status),
    .i_gate        (i_gate),
    .i_decimator   (i_decimator),
    .o_sample      (o_sample)
  );

  // One 60-cycle gate period (30 high, 30 low) starting from a closed gate.
  // Cycle c is the c-th rising edge after i_gate rises; active spans c=3..32.
  task automatic run_window(input string name, input logic [3:0] status,
                            input logic [W-1:0] n, input int unsigned drop_at,
                            input int unsigned restore_at, input int unsigned change_at,
                            input logic [W-1:0] new_n, input int exp_pulses);
    int unsigned k;
    int unsigned nq;
    int          pulses;
    logic        exp;
    logic        got;
    bit          act;
    k = 0; nq = 0; pulses = 0;
    i_decimator   = n;
    i_iagc_status = status;
    i_gate        = 1'b1;
    for (int unsigned c = 1; c <= 60; c++) begin
      if (c == drop_at)    i_iagc_status = 4'b0001;
      if (c == restore_at) i_iagc_status = status;
      if (c == change_at)  i_decimator = new_n;
      if (c == 31)         i_gate = 1'b0;
      if (c == 3)          nq = i_decimator;
      act = (c >= 3) && (c <= 32) && i_iagc_status[0] && i_iagc_status[1];
      if (act && nq != 0) begin
        k++;
        exp = (k % nq == 0);
      end else begin
        k = 0;
        exp = 1'b0;
      end
      exp_q.push_back(exp);
      @(posedge i_clock);
      @(negedge i_clock);
      got = exp_q.pop_front();
      if (o_sample === 1'b1) pulses++;
      checks++;
      if (o_sample !== got) begin
        failures++;
        $display("FAIL %s cycle %0d o_sample=%b expected=%b", name, c, o_sample, got);
      end
    end
    checks++;
    if (pulses != exp_pulses) begin
      failures++;
      $display("FAIL %s pulse_count got=%0d expected=%0d", name, pulses, exp_pulses);
    end
  endtask

  task automatic test_reset();
    logic got;
    i_reset = 1'b1; i_gate = 1'b0; i_iagc_status = 4'b0000; i_decimator = '0;
    repeat (3) @(negedge i_clock);
    checks++;
    if (o_sample !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold o_sample=%b expected=0", o_sample);
    end
    i_reset = 1'b0;
    for (int unsigned c = 0; c < 5; c++) begin
      exp_q.push_back(1'b0);
      @(posedge i_clock);
      @(negedge i_clock);
      got = exp_q.pop_front();
      checks++;
      if (o_sample !== got) begin
        failures++;
        $display("FAIL reset_idle cycle %0d o_sample=%b expected=%b", c, o_sample, got);
      end
    end
  endtask

  task automatic test_status_gating();
    run_window("status_0000", 4'b0000, 4'd1, 0, 0, 0, 4'd1, 0);
    run_window("status_0001", 4'b0001, 4'd1, 0, 0, 0, 4'd1, 0);
    run_window("status_1101", 4'b1101, 4'd1, 0, 0, 0, 4'd1, 0);
  endtask

  task automatic test_n_change();
    run_window("n1_change_to4", 4'b0011, 4'd1, 0, 0, 10, 4'd4, 30);
    run_window("n4",            4'b0011, 4'd4, 0, 0, 10, 4'd2, 7);
    run_window("n2",            4'b1111, 4'd2, 0, 0, 0,  4'd2, 15);
  endtask

  task automatic test_boundaries();
    run_window("n0_a",  4'b0011, 4'd0,  0, 0, 0, 4'd0, 0);
    run_window("n0_b",  4'b0011, 4'd0,  0, 0, 0, 4'd0, 0);
    run_window("n15",   4'b0011, 4'd15, 0, 0, 0, 4'd15, 2);
  endtask

  task automatic test_status_drop();
    run_window("status_drop", 4'b0011, 4'd4, 12, 20, 0, 4'd4, 5);
  endtask

  task automatic test_reset_mid_window();
    logic got;
    i_decimator = 4'd1; i_iagc_status = 4'b0011; i_gate = 1'b1;
    for (int unsigned c = 1; c <= 12; c++) begin
      exp_q.push_back(c >= 3);
      @(posedge i_clock);
      @(negedge i_clock);
      got = exp_q.pop_front();
      checks++;
      if (o_sample !== got) begin
        failures++;
        $display("FAIL pre_reset cycle %0d o_sample=%b expected=%b", c, o_sample, got);
      end
    end
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_sample !== 1'b0) begin
      failures++;
      $display("FAIL reset_async o_sample=%b expected=0", o_sample);
    end
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    for (int unsigned c = 0; c < 50; c++) begin
      if (c == 20) i_gate = 1'b0;
      exp_q.push_back(1'b0);
      @(posedge i_clock);
      @(negedge i_clock);
      got = exp_q.pop_front();
      checks++;
      if (o_sample !== got) begin
        failures++;
        $display("FAIL post_reset cycle %0d o_sample=%b expected=%b", c, o_sample, got);
      end
    end
    run_window("after_reset", 4'b0011, 4'd1, 0, 0, 0, 4'd1, 30);
  endtask

  initial begin
    test_reset();
    test_status_gating();
    test_n_change();
    test_boundaries();
    test_status_drop();
    test_reset_mid_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decimator.md
DECIMATOR -- requirements
Module: decimator

Interface
REQ-001 The block SHALL have one parameter, DECIMATOR_SIZE, default 4, which sets the bit width of the decimation factor and of the internal counter.
REQ-002 The block SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_iagc_status, input, 4 bits: IAGC status word, where bit0 = IAGC enabled, bit1 = IAGC acquiring, and bits 3:2 are ignored.
REQ-005 The block SHALL have port i_gate, input, 1 bit: acquisition gate, asynchronous to i_clock, active high.
REQ-006 The block SHALL have port i_decimator, input, DECIMATOR_SIZE bits: decimation factor N, unsigned.
REQ-007 The block SHALL have port o_sample, output, 1 bit: registered single-cycle sample strobe.

Function
REQ-008 i_gate SHALL pass through a 2-flop synchronizer; gate_s is the second flop's output.
REQ-009 A gate window SHALL open on the first cycle gate_s = 1 after gate_s = 0, and close on the first cycle gate_s = 0.
REQ-010 The block SHALL define active = i_iagc_status[0] AND i_iagc_status[1] AND gate_s, sampled every cycle.
REQ-011 i_decimator SHALL be latched into n_q on the cycle a gate window opens; changes to i_decimator inside an open window SHALL take effect only at the next window opening.
REQ-012 On every rising edge with active = 1 and n_q >= 1:
- if cnt == n_q-1: cnt <= 0 and o_sample <= 1;
- otherwise: cnt <= cnt+1 and o_sample <= 0.
REQ-013 With n_q = 1, o_sample SHALL be high on every active cycle.
REQ-014 With n_q = 0, o_sample SHALL stay 0 and cnt SHALL hold 0 (decimation disabled).
REQ-015 With active = 0 (gate closed, or either status bit low), cnt <= 0 and o_sample <= 0 on the next edge; a window that is resumed restarts counting from 0.
REQ-016 With a window open at constant n_q = N >= 1, the first o_sample pulse SHALL occur N cycles after active first goes high, and then every N cycles.
REQ-017 A status bit that drops mid-window SHALL behave as the gate closing: counter cleared, and no pulse on the dropping edge.
REQ-018 cnt SHALL be DECIMATOR_SIZE bits wide and SHALL never exceed n_q-1, so no wrap-around occurs.

Reset
REQ-019 i_reset high SHALL immediately (asynchronously) force:
- o_sample = 0, cnt = 0, n_q = 0;
- both synchronizer flops = 0, and the window-open flag = 0.
REQ-020 After reset is released, the block SHALL require a fresh gate-window opening before any pulse can occur, even if i_gate is already high.

Structure
REQ-021 No shared package is required; the status bit indices (ENABLE = 0, ACQUIRE = 1) SHALL be defined as named constants in the shared IAGC package if one exists, otherwise as local constants.
REQ-022 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, async active-high reset to 0); all other logic stays in decimator.

Verification (10 ns clock, gate toggling every 300 ns, i.e. 30-cycle windows)
REQ-023 Status 4'b0000, then 4'b0001, with gate toggling and N = 1 -> o_sample remains 0 throughout.
REQ-024 Status 4'b0011, N = 1 -> o_sample is high on each of the 30 active cycles per window and low while the gate is closed; the first pulse comes 3 clocks after the i_gate rise (2 synchronizer cycles plus the register).
REQ-025 N changed to 4 while a window is open -> the current window keeps N = 1; the next window gives 7 pulses, spaced 4 cycles apart, the first 4 cycles after active rises.
REQ-026 N changed to 2 -> 15 pulses per window in the following window; with N = 0 there are no pulses in any window.
REQ-027 i_reset asserted mid-window -> o_sample is 0 in the same cycle; after release with i_gate still high, there are no pulses until the gate falls and rises again.
REQ-028 Status drops from 4'b0011 to 4'b0001 mid-window with N = 4 -> pulses stop within one cycle; on restoring 4'b0011 the first pulse comes 4 cycles later.
